// File: rtl/bebida_dispensador.sv
// ---------------------------------------------------------------------------
// bebida_dispensador
//
// Dispense controller that sits directly after the drink menu FSM. On a rising
// edge of the menu's select-active flag it captures a one-hot drink choice and
// checks the cup and water sensors. It then heats for a fixed time and pours
// for a time that depends on the drink. When the pour finishes it pulses
// clr_menu so the menu returns to its top option.
//
// Optional feature macro: DISP_COUNT_EN
//   defined   -> adds the 8-bit served_cnt output, a saturating count of
//                completed drinks
//   undefined -> no served_cnt port and no counter
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   sel_valid    in   menu select-active flag; only its rising edge starts
//                     a sequence
//   drink[3:0]   in   one-hot drink selection (bit i = drink i)
//   cup_present  in   cup sensor, 1 = cup in place
//   water_ok     in   tank level sensor, 1 = enough water
//   cancel       in   user cancel / error acknowledge
//   heater       out  heater enable (HEAT)
//   pump         out  pump enable (POUR)
//   valve[3:0]   out  one-hot ingredient valve, open only during POUR
//   busy         out  high in every state except IDLE
//   done         out  drink-ready indicator (DONE)
//   error        out  fault indicator (ERR)
//   clr_menu     out  registered 1-cycle pulse to the menu CLC input
//   served_cnt   out  drinks served (only with DISP_COUNT_EN)
//
// TMR_W must be wide enough to hold POUR_BASE + 3*POUR_STEP - 1.
// ---------------------------------------------------------------------------
module bebida_dispensador #(
    parameter int unsigned TMR_W     = 16,
    parameter int unsigned HEAT_CYC  = 50,
    parameter int unsigned POUR_BASE = 20,
    parameter int unsigned POUR_STEP = 10,
    parameter int unsigned DONE_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_valid,
    input  logic [3:0] drink,
    input  logic       cup_present,
    input  logic       water_ok,
    input  logic       cancel,
    output logic       heater,
    output logic       pump,
    output logic [3:0] valve,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       clr_menu
`ifdef DISP_COUNT_EN
    ,
    output logic [7:0] served_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        HEAT  = 3'd2,
        POUR  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic [3:0]        drink_reg;
    logic [1:0]        idx_reg;
    logic              sel_prev_reg;
    logic              clr_menu_reg;

    // Pour length per drink index, already reduced by one for the down-counter.
    logic [TMR_W-1:0]  pour_tbl [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pour_tbl
            assign pour_tbl[gi] = TMR_W'(POUR_BASE + gi * POUR_STEP - 1);
        end
    endgenerate

    localparam logic [TMR_W-1:0] HEAT_LOAD = TMR_W'(HEAT_CYC - 1);
    localparam logic [TMR_W-1:0] DONE_LOAD = TMR_W'(DONE_HOLD - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    logic drink_onehot;
    assign drink_onehot = (drink != 4'b0000) && ((drink & (drink - 4'd1)) == 4'b0000);

    logic [1:0] sel_idx;
    always_comb begin
        sel_idx = 2'd0;
        case (drink)
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    logic start;
    logic sensors_ok;
    logic timer_zero;
    logic pour_done;

    assign start      = sel_valid && !sel_prev_reg && (state_reg == IDLE) && drink_onehot;
    assign sensors_ok = cup_present && water_ok;
    assign timer_zero = (timer_reg == '0);
    // Last POUR cycle with no cancel and no fault: the sequence completes.
    assign pour_done  = (state_reg == POUR) && !cancel && sensors_ok && timer_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            drink_reg    <= 4'b0000;
            idx_reg      <= 2'd0;
            sel_prev_reg <= 1'b0;
            clr_menu_reg <= 1'b0;
        end else begin
            sel_prev_reg <= sel_valid;
            clr_menu_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        drink_reg <= drink;
                        idx_reg   <= sel_idx;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (cancel) begin
                        state_reg    <= IDLE;
                        drink_reg    <= 4'b0000;
                        clr_menu_reg <= 1'b1;
                    end else if (!sensors_ok) begin
                        state_reg <= ERR;
                    end else begin
                        state_reg <= HEAT;
                        timer_reg <= HEAT_LOAD;
                    end
                end
                HEAT, POUR: begin
                    // Cancel outranks a sensor fault; a fault outranks the timer.
                    if (cancel) begin
                        state_reg    <= IDLE;
                        drink_reg    <= 4'b0000;
                        clr_menu_reg <= 1'b1;
                    end else if (!sensors_ok) begin
                        state_reg <= ERR;
                    end else if (timer_zero) begin
                        if (state_reg == HEAT) begin
                            state_reg <= POUR;
                            timer_reg <= pour_tbl[idx_reg];
                        end else begin
                            state_reg    <= DONE;
                            timer_reg    <= DONE_LOAD;
                            clr_menu_reg <= 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg - TMR_ONE;
                    end
                end
                DONE: begin
                    if (timer_zero) begin
                        state_reg <= IDLE;
                        drink_reg <= 4'b0000;
                    end else begin
                        timer_reg <= timer_reg - TMR_ONE;
                    end
                end
                ERR: begin
                    if (cancel) begin
                        state_reg    <= IDLE;
                        drink_reg    <= 4'b0000;
                        clr_menu_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    drink_reg <= 4'b0000;
                end
            endcase
        end
    end

    // Moore outputs straight from the state register, so an async reset or a
    // move to ERR drops the actuators without any extra logic.
    assign heater   = (state_reg == HEAT);
    assign pump     = (state_reg == POUR);
    assign valve    = (state_reg == POUR) ? drink_reg : 4'b0000;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign error    = (state_reg == ERR);
    assign clr_menu = clr_menu_reg;

`ifdef DISP_COUNT_EN
    logic [7:0] served_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            served_cnt_reg <= 8'd0;
        end else if (pour_done && (served_cnt_reg != 8'hFF)) begin
            served_cnt_reg <= served_cnt_reg + 8'd1;
        end
    end

    assign served_cnt = served_cnt_reg;
`endif

endmodule

// File: tb/tb_bebida_dispensador.sv
// ---------------------------------------------------------------------------
// tb_bebida_dispensador
//
// Directed testbench for bebida_dispensador with short timings
// (HEAT_CYC=4, POUR_BASE=3, POUR_STEP=2, DONE_HOLD=2). Each scenario task
// drives stimulus and compares outputs against hand-derived timelines.
// Outputs are sampled 1 time unit after the rising clock edge. The
// served_cnt scenario runs only when DISP_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_bebida_dispensador;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel_valid;
    logic [3:0] drink;
    logic       cup_present;
    logic       water_ok;
    logic       cancel;
    logic       heater;
    logic       pump;
    logic [3:0] valve;
    logic       busy;
    logic       done;
    logic       error;
    logic       clr_menu;
`ifdef DISP_COUNT_EN
    logic [7:0] served_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bebida_dispensador #(
        .TMR_W    (16),
        .HEAT_CYC (4),
        .POUR_BASE(3),
        .POUR_STEP(2),
        .DONE_HOLD(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel_valid  (sel_valid),
        .drink      (drink),
        .cup_present(cup_present),
        .water_ok   (water_ok),
        .cancel     (cancel),
        .heater     (heater),
        .pump       (pump),
        .valve      (valve),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .clr_menu   (clr_menu)
`ifdef DISP_COUNT_EN
        ,
        .served_cnt (served_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output vector order: {heater, pump, valve[3:0], busy, done, error, clr_menu}
    task automatic test_reset();
        logic [9:0] got;
        reset = 1'b1; sel_valid = 1'b0; drink = 4'b0000;
        cup_present = 1'b1; water_ok = 1'b1; cancel = 1'b0;
        tick(); tick();
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b0) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", got, 10'b0);
        end
        reset = 1'b0;
        tick();
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", got, 10'b0);
        end
        $display("test_reset done");
    endtask

    // Full good sequence for a drink with index idx; every cycle is compared.
    task automatic run_good(input logic [3:0] d, input int idx, input bit hold, input string name);
        int pour;
        int total;
        int heat_seen;
        int busy_seen;
        logic [9:0] got;
        logic [9:0] exp;
        logic e_heat, e_pump, e_busy, e_done, e_clr;
        logic [3:0] e_valve;
        pour  = 3 + 2 * idx;
        total = 1 + 4 + pour + 2;
        heat_seen = 0;
        busy_seen = 0;
        sel_valid = 1'b0; drink = d;
        tick();
        sel_valid = 1'b1;
        for (int n = 1; n <= total + 2; n++) begin
            tick();
            e_heat  = (n >= 2) && (n <= 5);
            e_pump  = (n >= 6) && (n <= 5 + pour);
            e_valve = e_pump ? d : 4'b0000;
            e_busy  = (n <= total);
            e_done  = (n >= total - 1) && (n <= total);
            e_clr   = (n == total - 1);
            exp = {e_heat, e_pump, e_valve, e_busy, e_done, 1'b0, e_clr};
            got = {heater, pump, valve, busy, done, error, clr_menu};
            if (heater === 1'b1) heat_seen++;
            if (busy === 1'b1) busy_seen++;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", name, n, got, exp);
            end
            if (!hold) sel_valid = 1'b0;
        end
        checks++;
        if (heat_seen != 4 || busy_seen != total) begin
            failures++;
            $display("FAIL %s_counts heater=%0d busy=%0d exp heater=4 busy=%0d",
                     name, heat_seen, busy_seen, total);
        end
        $display("%s drink=%b pour=%0d busy_cycles=%0d", name, d, pour, busy_seen);
    endtask

    task automatic test_good_drink();
        run_good(4'b0100, 2, 1'b0, "good_d2");
        run_good(4'b1000, 3, 1'b0, "good_d3");
    endtask

    task automatic test_bad_select();
        sel_valid = 1'b0; drink = 4'b0011;
        tick();
        sel_valid = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL multi_hot cyc=%0d busy=%b exp=0", n, busy);
            end
        end
        sel_valid = 1'b0; drink = 4'b0000;
        tick();
        sel_valid = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_hot busy=%b exp=0", busy);
        end
        $display("test_bad_select multi_hot and zero_hot ignored");
        // Held select after a completed drink must not restart.
        run_good(4'b0001, 0, 1'b1, "held_d0");
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL held_restart cyc=%0d busy=%b exp=0", n, busy);
            end
        end
        sel_valid = 1'b0;
        tick();
        $display("test_bad_select held select done");
    endtask

    task automatic test_cup_error();
        logic [9:0] got;
        sel_valid = 1'b0; drink = 4'b0010; cup_present = 1'b0;
        tick();
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b00_0000_1000) begin
            failures++;
            $display("FAIL cup_check got=%b exp=%b", got, 10'b00_0000_1000);
        end
        for (int n = 1; n <= 3; n++) begin
            tick();
            got = {heater, pump, valve, busy, done, error, clr_menu};
            checks++;
            if (got !== 10'b00_0000_1010) begin
                failures++;
                $display("FAIL cup_err cyc=%0d got=%b exp=%b", n, got, 10'b00_0000_1010);
            end
        end
        cup_present = 1'b1;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b00_0000_0001) begin
            failures++;
            $display("FAIL cup_cancel got=%b exp=%b", got, 10'b00_0000_0001);
        end
        tick();
        checks++;
        if (clr_menu !== 1'b0) begin
            failures++;
            $display("FAIL cup_clr_width clr_menu=%b exp=0", clr_menu);
        end
        $display("test_cup_error done");
    endtask

    // Start drink 3 and stop at the second POUR cycle (n=7).
    task automatic start_to_pour2(input string name);
        sel_valid = 1'b0; drink = 4'b1000;
        tick();
        sel_valid = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            sel_valid = 1'b0;
        end
        checks++;
        if ({pump, valve} !== 5'b1_1000) begin
            failures++;
            $display("FAIL %s_pour2 got=%b exp=%b", name, {pump, valve}, 5'b1_1000);
        end
    endtask

    task automatic test_water_fault();
        logic [9:0] got;
        start_to_pour2("wf");
        water_ok = 1'b0;
        tick();
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b00_0000_1010) begin
            failures++;
            $display("FAIL water_fault got=%b exp=%b", got, 10'b00_0000_1010);
        end
        water_ok = 1'b1;
        tick();
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL water_err_sticky error=%b exp=1", error);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b00_0000_0001) begin
            failures++;
            $display("FAIL water_ack got=%b exp=%b", got, 10'b00_0000_0001);
        end
        $display("test_water_fault fault then ack done");
        start_to_pour2("wc");
        water_ok = 1'b0; cancel = 1'b1;
        tick();
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b00_0000_0001) begin
            failures++;
            $display("FAIL cancel_over_fault got=%b exp=%b", got, 10'b00_0000_0001);
        end
        water_ok = 1'b1; cancel = 1'b0;
        tick();
        $display("test_water_fault cancel priority done");
    endtask

    task automatic test_reset_mid();
        logic [9:0] got;
        sel_valid = 1'b0; drink = 4'b0001;
        tick();
        sel_valid = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            sel_valid = 1'b0;
        end
        checks++;
        if (heater !== 1'b1) begin
            failures++;
            $display("FAIL mid_heat heater=%b exp=1", heater);
        end
        reset = 1'b1;
        #1;
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", got, 10'b0);
        end
        tick();
        reset = 1'b0;
        tick();
        got = {heater, pump, valve, busy, done, error, clr_menu};
        checks++;
        if (got !== 10'b0) begin
            failures++;
            $display("FAIL reset_no_clr got=%b exp=%b", got, 10'b0);
        end
        $display("test_reset_mid outputs cleared");
        run_good(4'b0100, 2, 1'b0, "after_reset");
    endtask

`ifdef DISP_COUNT_EN
    task automatic quick_serve();
        sel_valid = 1'b0; drink = 4'b0001;
        tick();
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        for (int n = 0; n < 11; n++) tick();
    endtask

    task automatic test_count();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (served_cnt !== 8'd0) begin
            failures++;
            $display("FAIL cnt_reset got=%0d exp=0", served_cnt);
        end
        for (int i = 0; i < 3; i++) quick_serve();
        sel_valid = 1'b0; drink = 4'b0010;
        tick();
        sel_valid = 1'b1;
        tick(); tick();
        sel_valid = 1'b0; cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        checks++;
        if (served_cnt !== 8'd3) begin
            failures++;
            $display("FAIL cnt_three got=%0d exp=3", served_cnt);
        end
        for (int i = 0; i < 251; i++) quick_serve();
        checks++;
        if (served_cnt !== 8'd254) begin
            failures++;
            $display("FAIL cnt_254 got=%0d exp=254", served_cnt);
        end
        quick_serve();
        quick_serve();
        checks++;
        if (served_cnt !== 8'd255) begin
            failures++;
            $display("FAIL cnt_sat got=%0d exp=255", served_cnt);
        end
        $display("test_count served_cnt=%0d", served_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_good_drink();
        test_bad_select();
        test_cup_error();
        test_water_fault();
        test_reset_mid();
`ifdef DISP_COUNT_EN
        test_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
